led_sequencer: RTL and testbench

Parametrised LED pattern engine for the board's user LEDs and status LED. It replaces the fixed 6-LED rotate/blink logic with N LEDs, four selectable patterns, millisecond-programmable step and blink periods, global PWM brightness, pause, and selectable pin polarity. It sits directly between the top-level control inputs (switches and buttons, already synchronised) and the LED pins.

---
 rtl/led_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_led_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// ============================================================================
// led_sequencer
//
// Purpose:
//   Parametrised LED pattern engine for the board's user LEDs and status LED.
//   A millisecond prescaler drives two independent period counters: one
//   advances the LED pattern (rotate-left, rotate-right, bounce or binary
//   count), the other toggles the red blink LED. A free-running 15-step PWM
//   dims the pattern LEDs, and the pin polarity is selectable.
//
// Parameters:
//   CLK_HZ      sys_clk frequency in Hz (informational; TICK_DIV is derived
//               from it by the integrator)
//   TICK_DIV    sys_clk cycles per 1 ms tick (>= 2)
//   NUM_LEDS    pattern width (>= 2)
//   ACTIVE_LOW  1 = a low pin lights the LED
//
// Ports:
//   sys_clk     in   1         single clock for the whole block
//   sys_rst_n   in   1         asynchronous active-low reset
//   mode        in   2         0 rotate-left, 1 rotate-right, 2 bounce,
//                              3 binary count
//   step_ms     in   16        pattern step period in ms (0 acts as 1)
//   blink_ms    in   16        red_led half-period in ms (0 acts as 1)
//   brightness  in   4         PWM duty = brightness/15
//   pause       in   1         high freezes the pattern
//   led         out  NUM_LEDS  LED pins, polarity set by ACTIVE_LOW
//   red_led     out  1         blink pin, polarity set by ACTIVE_LOW
//   step_pulse  out  1         one-cycle strobe on each pattern advance
// ============================================================================
module led_sequencer #(
  parameter int unsigned CLK_HZ     = 27_000_000,
  parameter int unsigned TICK_DIV   = 27_000,
  parameter int unsigned NUM_LEDS   = 6,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [1:0]          mode,
  input  logic [15:0]         step_ms,
  input  logic [15:0]         blink_ms,
  input  logic [3:0]          brightness,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] led,
  output logic                red_led,
  output logic                step_pulse
);

  localparam int unsigned PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned POS_W = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] PAT_INIT = NUM_LEDS'(1);
  localparam logic [3:0]          PWM_LAST = 4'd14;

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'd0,
    MODE_ROTR   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  // Refuse to elaborate with parameters the counters cannot honour.
  if (TICK_DIV < 2 || NUM_LEDS < 2 || CLK_HZ < TICK_DIV) begin : g_bad_params
    $error("led_sequencer: TICK_DIV and NUM_LEDS must be >= 2, CLK_HZ >= TICK_DIV");
  end

  logic [PRE_W-1:0]    pre_cnt;
  logic                ms_tick;

  logic [15:0]         step_cnt;
  logic [15:0]         step_term;
  logic                step_at_term;
  logic                step_go;

  logic [15:0]         blink_cnt;
  logic [15:0]         blink_term;
  logic                blink_at_term;
  logic                blink;

  logic [NUM_LEDS-1:0] pat,      pat_nxt;
  logic [POS_W-1:0]    pos,      pos_nxt;
  logic                dir,      dir_nxt;
  mode_e               cur_mode, cur_mode_nxt;

  logic [3:0]          pwm_cnt;
  logic                pwm_on;

  // A zero period is treated as one millisecond, so the terminal count is
  // max(period,1)-1. Comparing with >= means shrinking a period below the
  // running count fires on the very next tick instead of wrapping through
  // 65536 milliseconds.
  always_comb begin
    step_term     = (step_ms  == 16'd0) ? 16'd0 : step_ms  - 16'd1;
    blink_term    = (blink_ms == 16'd0) ? 16'd0 : blink_ms - 16'd1;
    ms_tick       = (pre_cnt == PRE_LAST);
    step_at_term  = (step_cnt >= step_term);
    blink_at_term = (blink_cnt >= blink_term);
    step_go       = ms_tick && !pause && step_at_term;
    pwm_on        = (pwm_cnt < brightness);
  end

  // Millisecond prescaler. It free-runs independently of pause so that the
  // blink rate and the step phase stay locked to wall-clock time.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_cnt <= '0;
    end else if (ms_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Step interval counter. At the terminal count it clears when the step is
  // taken, but while paused it parks at terminal so that releasing pause
  // steps on the very next millisecond tick. Below terminal it keeps
  // counting even while paused.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      step_cnt <= '0;
    end else if (ms_tick) begin
      if (step_at_term) begin
        if (!pause) begin
          step_cnt <= '0;
        end
      end else begin
        step_cnt <= step_cnt + 16'd1;
      end
    end
  end

  // Blink half-period counter. Same shape as the step counter but pause has
  // no effect, so the status LED keeps blinking while the pattern is frozen.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (ms_tick) begin
      if (blink_at_term) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  // Pattern state register. All pattern fields move together on a step; the
  // next values are worked out in the combinational block below.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pat      <= PAT_INIT;
      pos      <= '0;
      dir      <= 1'b0;
      cur_mode <= MODE_ROTL;
    end else begin
      pat      <= pat_nxt;
      pos      <= pos_nxt;
      dir      <= dir_nxt;
      cur_mode <= cur_mode_nxt;
    end
  end

  // Next pattern state. The mode input is only looked at on a step: a new
  // mode restarts from a single lit LED at position 0 moving up, and the
  // advance that would otherwise happen on that step is skipped. Bounce
  // turns round at the end it has just reached, so each endpoint is shown
  // for exactly one step and no position repeats.
  always_comb begin
    pat_nxt      = pat;
    pos_nxt      = pos;
    dir_nxt      = dir;
    cur_mode_nxt = cur_mode;
    if (step_go) begin
      if (mode != cur_mode) begin
        cur_mode_nxt = mode_e'(mode);
        pat_nxt      = PAT_INIT;
        pos_nxt      = '0;
        dir_nxt      = 1'b0;
      end else begin
        case (cur_mode)
          MODE_ROTL: begin
            pat_nxt = {pat[NUM_LEDS-2:0], pat[NUM_LEDS-1]};
          end
          MODE_ROTR: begin
            pat_nxt = {pat[0], pat[NUM_LEDS-1:1]};
          end
          MODE_BOUNCE: begin
            if (!dir) begin
              pos_nxt = pos + 1'b1;
              if (pos_nxt == POS_LAST) begin
                dir_nxt = 1'b1;
              end
            end else begin
              pos_nxt = pos - 1'b1;
              if (pos_nxt == '0) begin
                dir_nxt = 1'b0;
              end
            end
            pat_nxt = PAT_INIT << pos_nxt;
          end
          MODE_COUNT: begin
            pat_nxt = pat + 1'b1;
          end
          default: begin
            pat_nxt = pat;
          end
        endcase
      end
    end
  end

  // Brightness PWM. Fifteen phases (0..14) so that brightness 15 is fully on
  // and brightness 0 is fully off with no stray pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt <= '0;
    end else if (pwm_cnt == PWM_LAST) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  // Registered pin drivers. The pattern is gated by the PWM phase and then
  // flipped for the board polarity; the blink LED is never dimmed. The step
  // strobe appears in the cycle after the step, alongside the new pattern,
  // and the pins follow one cycle later.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led        <= {NUM_LEDS{ACTIVE_LOW}};
      red_led    <= ACTIVE_LOW;
      step_pulse <= 1'b0;
    end else begin
      led        <= (pat & {NUM_LEDS{pwm_on}}) ^ {NUM_LEDS{ACTIVE_LOW}};
      red_led    <= blink ^ ACTIVE_LOW;
      step_pulse <= step_go;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// ============================================================================
// tb_led_sequencer
//
// Purpose:
//   Self-checking bench for led_sequencer built with TICK_DIV=4, NUM_LEDS=6,
//   ACTIVE_LOW=1. Cycle k means the state after k rising edges following
//   reset release; outputs are sampled on the falling edge.
// ============================================================================
module tb_led_sequencer;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned NUM_LEDS = 6;

  typedef struct {
    int          at_cycle;
    logic [1:0]  mode;
    logic [15:0] step_ms;
    logic [3:0]  brightness;
    logic        pause;
    logic [5:0]  exp_led;
    logic        exp_pulse;
    string       name;
  } vec_t;

  logic                sys_clk    = 1'b0;
  logic                sys_rst_n  = 1'b0;
  logic [1:0]          mode       = 2'd0;
  logic [15:0]         step_ms    = 16'd2;
  logic [15:0]         blink_ms   = 16'd3;
  logic [3:0]          brightness = 4'd15;
  logic                pause      = 1'b0;
  logic [NUM_LEDS-1:0] led;
  logic                red_led;
  logic                step_pulse;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  vec_t t1_vec [12];
  int   bounce_pos [11];

  led_sequencer #(
    .CLK_HZ     (4000),
    .TICK_DIV   (TICK_DIV),
    .NUM_LEDS   (NUM_LEDS),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .mode       (mode),
    .step_ms    (step_ms),
    .blink_ms   (blink_ms),
    .brightness (brightness),
    .pause      (pause),
    .led        (led),
    .red_led    (red_led),
    .step_pulse (step_pulse)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 sys_clk = ~sys_clk;

  // Compare one observed value against its expectation and log any miss.
  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b",
               name, cyc, actual, expected);
    end
  endtask

  // Advance to an absolute cycle number, sampling point on the falling edge.
  task automatic runTo(input int target);
    while (cyc < target) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      cyc++;
    end
  endtask

  // Hold reset for a few clocks and release it on a falling edge.
  task automatic resetDut();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cyc = 0;
  endtask

  // Drive one table row's inputs, then run to its sampling cycle.
  task automatic applyStimulus(input vec_t v);
    mode       = v.mode;
    step_ms    = v.step_ms;
    brightness = v.brightness;
    pause      = v.pause;
    runTo(v.at_cycle);
  endtask

  // Expected red_led for blink_ms=3 from reset: dark until cycle 12, then
  // toggling every 12 cycles.
  function automatic logic redExpected(input int c);
    if (c == 0) return 1'b1;
    return 1'b1 ^ logic'(((c - 1) / 12) % 2);
  endfunction

  // Bounded run time in case the clock or a task misbehaves.
  initial begin
    #200_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lit;
    int other_lit;
    logic [5:0] exp_led;

    t1_vec[0]  = '{0,  2'd0, 16'd2, 4'd15, 1'b0, 6'b111111, 1'b0, "t1_reset"};
    t1_vec[1]  = '{1,  2'd0, 16'd2, 4'd15, 1'b0, 6'b111110, 1'b0, "t1_first_update"};
    t1_vec[2]  = '{7,  2'd0, 16'd2, 4'd15, 1'b0, 6'b111110, 1'b0, "t1_pre_step"};
    t1_vec[3]  = '{8,  2'd0, 16'd2, 4'd15, 1'b0, 6'b111110, 1'b1, "t1_step1_pulse"};
    t1_vec[4]  = '{9,  2'd0, 16'd2, 4'd15, 1'b0, 6'b111101, 1'b0, "t1_step1_pin"};
    t1_vec[5]  = '{16, 2'd0, 16'd2, 4'd15, 1'b0, 6'b111101, 1'b1, "t1_step2_pulse"};
    t1_vec[6]  = '{17, 2'd0, 16'd2, 4'd15, 1'b0, 6'b111011, 1'b0, "t1_step2_pin"};
    t1_vec[7]  = '{25, 2'd0, 16'd2, 4'd15, 1'b0, 6'b110111, 1'b0, "t1_step3_pin"};
    t1_vec[8]  = '{33, 2'd0, 16'd2, 4'd15, 1'b0, 6'b101111, 1'b0, "t1_step4_pin"};
    t1_vec[9]  = '{41, 2'd0, 16'd2, 4'd15, 1'b0, 6'b011111, 1'b0, "t1_step5_pin"};
    t1_vec[10] = '{48, 2'd0, 16'd2, 4'd15, 1'b0, 6'b011111, 1'b1, "t1_step6_pulse"};
    t1_vec[11] = '{49, 2'd0, 16'd2, 4'd15, 1'b0, 6'b111110, 1'b0, "t1_wrap"};

    bounce_pos = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};

    // T1: reset values and rotate-left stepping every 8 cycles.
    $display("[TB] T1 reset and rotate-left");
    blink_ms = 16'd3;
    resetDut();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(t1_vec[i]);
      checkOutput({t1_vec[i].name, "_led"}, {2'b00, led}, {2'b00, t1_vec[i].exp_led});
      checkOutput({t1_vec[i].name, "_pulse"}, {7'd0, step_pulse}, {7'd0, t1_vec[i].exp_pulse});
    end

    // T2: switch to bounce mid-interval; the next step only reloads.
    $display("[TB] T2 bounce and mode sampling");
    mode = 2'd2;
    runTo(54);
    checkOutput("t2_before_step", {2'b00, led}, 8'b0011_1110);
    runTo(56);
    checkOutput("t2_reload_pulse", {7'd0, step_pulse}, 8'd1);
    runTo(57);
    checkOutput("t2_reload_pin", {2'b00, led}, 8'b0011_1110);
    for (int j = 1; j <= 11; j++) begin
      runTo(57 + 8 * j);
      exp_led = ~(6'd1 << bounce_pos[j-1]);
      checkOutput($sformatf("t2_bounce_%0d", j), {2'b00, led}, {2'b00, exp_led});
    end

    // T3: binary count with step_ms=0 (a step every ms tick).
    $display("[TB] T3 binary count and step_ms zero");
    mode     = 2'd3;
    step_ms  = 16'd0;
    resetDut();
    runTo(4);
    checkOutput("t3_pulse_c4", {7'd0, step_pulse}, 8'd1);
    runTo(5);
    checkOutput("t3_pat1", {2'b00, led}, 8'b0011_1110);
    runTo(8);
    checkOutput("t3_pulse_c8", {7'd0, step_pulse}, 8'd1);
    runTo(9);
    checkOutput("t3_pat2", {2'b00, led}, 8'b0011_1101);
    runTo(253);
    checkOutput("t3_pat63", {2'b00, led}, 8'b0000_0000);
    runTo(254);
    checkOutput("t3_no_pulse_c254", {7'd0, step_pulse}, 8'd0);
    runTo(256);
    checkOutput("t3_pulse_c256", {7'd0, step_pulse}, 8'd1);
    runTo(257);
    checkOutput("t3_pat0", {2'b00, led}, 8'b0011_1111);
    runTo(261);
    checkOutput("t3_pat1_again", {2'b00, led}, 8'b0011_1110);

    // T4: PWM duty with a pattern held still by a long step period.
    $display("[TB] T4 PWM duty");
    mode       = 2'd0;
    step_ms    = 16'd100;
    brightness = 4'd5;
    resetDut();
    runTo(20);
    lit = 0;
    other_lit = 0;
    for (int c = 21; c <= 35; c++) begin
      runTo(c);
      if (led[0] == 1'b0) lit++;
      if (led[5:1] != 5'b11111) other_lit++;
    end
    checkOutput("t4_duty5_count", 8'(lit), 8'd5);
    checkOutput("t4_duty5_unlit_pins", 8'(other_lit), 8'd0);
    runTo(46);
    checkOutput("t4_phase_on", {2'b00, led}, 8'b0011_1110);
    runTo(51);
    checkOutput("t4_phase_off", {2'b00, led}, 8'b0011_1111);
    brightness = 4'd0;
    runTo(52);
    lit = 0;
    for (int c = 53; c <= 67; c++) begin
      runTo(c);
      if (led != 6'b111111) lit++;
    end
    checkOutput("t4_duty0_count", 8'(lit), 8'd0);
    brightness = 4'd15;
    runTo(68);
    lit = 0;
    for (int c = 69; c <= 83; c++) begin
      runTo(c);
      if (led == 6'b111110) lit++;
    end
    checkOutput("t4_duty15_count", 8'(lit), 8'd15);

    // T5: pause for 40 cycles while the blink LED keeps running.
    $display("[TB] T5 pause and blink");
    mode       = 2'd0;
    step_ms    = 16'd2;
    blink_ms   = 16'd3;
    brightness = 4'd15;
    pause      = 1'b0;
    resetDut();
    runTo(9);
    checkOutput("t5_step1_pin", {2'b00, led}, 8'b0011_1101);
    runTo(10);
    pause = 1'b1;
    for (int c = 11; c <= 51; c++) begin
      runTo(c);
      checkOutput($sformatf("t5_paused_pulse_%0d", c), {7'd0, step_pulse}, 8'd0);
      checkOutput($sformatf("t5_frozen_led_%0d", c), {2'b00, led}, 8'b0011_1101);
      checkOutput($sformatf("t5_red_%0d", c), {7'd0, red_led}, {7'd0, redExpected(c)});
      if (c == 49) pause = 1'b0;
    end
    runTo(52);
    checkOutput("t5_resume_pulse", {7'd0, step_pulse}, 8'd1);
    runTo(53);
    checkOutput("t5_resume_pin", {2'b00, led}, 8'b0011_1011);
    checkOutput("t5_red_c53", {7'd0, red_led}, {7'd0, redExpected(53)});

    // T6a: asynchronous reset between clock edges, then a clean restart.
    $display("[TB] T6 async reset and step_ms shrink");
    blink_ms = 16'd1;
    resetDut();
    runTo(16);
    checkOutput("t6_pre_led", {2'b00, led}, 8'b0011_1101);
    checkOutput("t6_pre_pulse", {7'd0, step_pulse}, 8'd1);
    checkOutput("t6_pre_red", {7'd0, red_led}, 8'd0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("t6_async_led", {2'b00, led}, 8'b0011_1111);
    checkOutput("t6_async_pulse", {7'd0, step_pulse}, 8'd0);
    checkOutput("t6_async_red", {7'd0, red_led}, 8'd1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cyc = 0;
    runTo(1);
    checkOutput("t6_restart_led", {2'b00, led}, 8'b0011_1110);
    runTo(4);
    checkOutput("t6_restart_red_c4", {7'd0, red_led}, 8'd1);
    runTo(5);
    checkOutput("t6_restart_red_c5", {7'd0, red_led}, 8'd0);
    runTo(7);
    checkOutput("t6_restart_no_pulse", {7'd0, step_pulse}, 8'd0);
    runTo(8);
    checkOutput("t6_restart_pulse", {7'd0, step_pulse}, 8'd1);

    // T6b: drop step_ms from 100 to 2 with step_cnt already at 50.
    step_ms  = 16'd100;
    blink_ms = 16'd3;
    resetDut();
    runTo(200);
    checkOutput("t6_shrink_pre_pulse", {7'd0, step_pulse}, 8'd0);
    checkOutput("t6_shrink_pre_led", {2'b00, led}, 8'b0011_1110);
    step_ms = 16'd2;
    runTo(203);
    checkOutput("t6_shrink_no_pulse", {7'd0, step_pulse}, 8'd0);
    runTo(204);
    checkOutput("t6_shrink_pulse", {7'd0, step_pulse}, 8'd1);
    runTo(205);
    checkOutput("t6_shrink_pin", {2'b00, led}, 8'b0011_1101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
